// File: rtl/hms_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clock_pkg : mode encoding and BCD limits shared by the hms_counter slice    |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_e;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MAX = 12;
  localparam int HR12_MIN = 1;

  // Binary 0..99 to a packed {tens, units} BCD pair.
  function automatic logic [7:0] to_bcd(input int value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hms_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hms_counter_if : tick/button inputs and BCD time outputs of hms_counter     |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
interface hms_counter_if;

  logic       tick_1s;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] hr_t;
  logic [3:0] hr_u;
  logic [3:0] min_t;
  logic [3:0] min_u;
  logic [3:0] sec_t;
  logic [3:0] sec_u;
  logic       pm;
  logic [1:0] mode;
  logic       chime;

  modport master (
    output tick_1s, btn_mode, btn_inc,
    input  hr_t, hr_u, min_t, min_u, sec_t, sec_u, pm, mode, chime
  );

  modport slave (
    input  tick_1s, btn_mode, btn_inc,
    output hr_t, hr_u, min_t, min_u, sec_t, sec_u, pm, mode, chime
  );

endinterface
`default_nettype wire

// File: rtl/hms_counter_bcd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_mod_counter : two-digit BCD counter wrapping MAX_VAL -> MIN_VAL         |
// | Revision        : 1.0                                                       |
// +----------------------------------------------------------------------------+
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MAX_VAL = 59,
  parameter int MIN_VAL = 0,
  parameter int RST_VAL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_inc,
  input  logic       i_clr,
  output logic [3:0] o_tens,
  output logic [3:0] o_units,
  output logic       o_carry
);

  localparam logic [7:0] c_MAX = to_bcd(MAX_VAL);
  localparam logic [7:0] c_MIN = to_bcd(MIN_VAL);
  localparam logic [7:0] c_RST = to_bcd(RST_VAL);

  logic [3:0] r_tens;
  logic [3:0] r_units;
  logic       w_at_max;

  assign w_at_max = ({r_tens, r_units} == c_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_tens, r_units} <= c_RST;
    end else if (i_clr) begin
      {r_tens, r_units} <= c_MIN;
    end else if (i_inc) begin
      if (w_at_max) begin
        {r_tens, r_units} <= c_MIN;
      end else if (r_units == 4'd9) begin
        r_units <= 4'd0;
        r_tens  <= r_tens + 4'd1;
      end else begin
        r_units <= r_units + 4'd1;
      end
    end
  end

  // Combinational so a full 23:59:59 rollover resolves in one edge.
  assign o_carry = i_inc & w_at_max;
  assign o_tens  = r_tens;
  assign o_units = r_units;

endmodule
`default_nettype wire

// File: rtl/hms_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hms_counter : BCD time-of-day with two-button set mode and hourly chime     |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module hms_counter
  import clock_pkg::*;
#(
  parameter int H24 = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  hms_counter_if.slave bus
);

  localparam int         c_HR_MAX     = (H24 != 0) ? HR24_MAX : HR12_MAX;
  localparam int         c_HR_MIN     = (H24 != 0) ? 0 : HR12_MIN;
  localparam int         c_HR_RST     = (H24 != 0) ? 0 : HR12_MAX;
  localparam logic [7:0] c_HR_PM_EDGE = to_bcd(HR12_MAX - 1);

  mode_e      r_mode;
  mode_e      w_mode_nxt;
  logic       r_chime;
  logic       w_run;
  logic       w_sec_inc;
  logic       w_sec_clr;
  logic       w_min_inc;
  logic       w_hr_inc;
  logic       w_sec_carry;
  logic       w_min_carry;
  logic       w_hr_wrap_unused;
  logic       w_set_inc;
  logic [3:0] w_hr_t;
  logic [3:0] w_hr_u;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_RUN;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (bus.btn_mode) begin
      case (r_mode)
        MODE_RUN:    w_mode_nxt = MODE_SET_HR;
        MODE_SET_HR: w_mode_nxt = MODE_SET_MIN;
        default:     w_mode_nxt = MODE_RUN;
      endcase
    end
  end

  // btn_mode wins over btn_inc in the set states.
  assign w_run     = (r_mode == MODE_RUN);
  assign w_set_inc = bus.btn_inc & ~bus.btn_mode;
  assign w_sec_inc = w_run & bus.tick_1s;
  assign w_sec_clr = (r_mode == MODE_SET_MIN) & bus.btn_mode;
  assign w_min_inc = w_run ? w_sec_carry : ((r_mode == MODE_SET_MIN) & w_set_inc);
  assign w_hr_inc  = w_run ? w_min_carry : ((r_mode == MODE_SET_HR) & w_set_inc);

  bcd_mod_counter #(
    .MAX_VAL (SEC_MAX),
    .MIN_VAL (0),
    .RST_VAL (0)
  ) u_sec (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_sec_inc),
    .i_clr   (w_sec_clr),
    .o_tens  (bus.sec_t),
    .o_units (bus.sec_u),
    .o_carry (w_sec_carry)
  );

  bcd_mod_counter #(
    .MAX_VAL (MIN_MAX),
    .MIN_VAL (0),
    .RST_VAL (0)
  ) u_min (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_min_inc),
    .i_clr   (1'b0),
    .o_tens  (bus.min_t),
    .o_units (bus.min_u),
    .o_carry (w_min_carry)
  );

  bcd_mod_counter #(
    .MAX_VAL (c_HR_MAX),
    .MIN_VAL (c_HR_MIN),
    .RST_VAL (c_HR_RST)
  ) u_hr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_hr_inc),
    .i_clr   (1'b0),
    .o_tens  (w_hr_t),
    .o_units (w_hr_u),
    .o_carry (w_hr_wrap_unused)
  );

  generate
    if (H24 != 0) begin : g_pm24
      assign bus.pm = 1'b0;
    end else begin : g_pm12
      logic r_pm;
      // pm flips on 11 -> 12, whether reached by counting or by setting.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pm <= 1'b0;
        end else if (w_hr_inc && ({w_hr_t, w_hr_u} == c_HR_PM_EDGE)) begin
          r_pm <= ~r_pm;
        end
      end
      assign bus.pm = r_pm;
    end
  endgenerate

  // Minute carry only reaches mm:ss = 00:00 via a RUN tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chime <= 1'b0;
    end else begin
      r_chime <= w_run & w_min_carry;
    end
  end

  assign bus.hr_t  = w_hr_t;
  assign bus.hr_u  = w_hr_u;
  assign bus.mode  = r_mode;
  assign bus.chime = r_chime;

endmodule
`default_nettype wire

// File: tb/tb_hms_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hms_counter : directed vectors for 24-hour and 12-hour hms_counter        |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_hms_counter;
  import clock_pkg::*;

  typedef struct {
    logic t;
    logic m;
    logic i;
    int   h;
    int   mi;
    int   s;
    int   md;
    logic ch;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[9];

  hms_counter_if bus24 ();
  hms_counter_if bus12 ();

  hms_counter #(.H24(1)) dut24 (.clk(clk), .rst_n(rst_n), .bus(bus24.slave));
  hms_counter #(.H24(0)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12.slave));

  always #10 clk = ~clk;

  function automatic logic [23:0] hms(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk24(input string nm, input int h, input int m, input int s,
                       input int md, input logic ch);
    chk({nm, " time"}, {8'h0, bus24.hr_t, bus24.hr_u, bus24.min_t, bus24.min_u,
                        bus24.sec_t, bus24.sec_u}, {8'h0, hms(h, m, s)});
    chk({nm, " mode"}, {30'h0, bus24.mode}, 32'(md));
    chk({nm, " chime"}, {31'h0, bus24.chime}, {31'h0, ch});
    chk({nm, " pm"}, {31'h0, bus24.pm}, 32'h0);
  endtask

  task automatic chk12(input string nm, input int h, input int m, input int s,
                       input logic p, input int md, input logic ch);
    chk({nm, " time"}, {8'h0, bus12.hr_t, bus12.hr_u, bus12.min_t, bus12.min_u,
                        bus12.sec_t, bus12.sec_u}, {8'h0, hms(h, m, s)});
    chk({nm, " pm"}, {31'h0, bus12.pm}, {31'h0, p});
    chk({nm, " mode"}, {30'h0, bus12.mode}, 32'(md));
    chk({nm, " chime"}, {31'h0, bus12.chime}, {31'h0, ch});
  endtask

  // Called at posedge+1: inputs are sampled by the next edge, then checked 1 ns later.
  task automatic cyc24(input logic t, input logic m, input logic i);
    bus24.tick_1s = t; bus24.btn_mode = m; bus24.btn_inc = i;
    @(posedge clk); #1;
    bus24.tick_1s = 1'b0; bus24.btn_mode = 1'b0; bus24.btn_inc = 1'b0;
  endtask

  task automatic cyc12(input logic t, input logic m, input logic i);
    bus12.tick_1s = t; bus12.btn_mode = m; bus12.btn_inc = i;
    @(posedge clk); #1;
    bus12.tick_1s = 1'b0; bus12.btn_mode = 1'b0; bus12.btn_inc = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // {tick, mode, inc} -> expected {h, m, s, mode, chime}, starting from 00:01:01 RUN
    vecs[0] = '{1'b0, 1'b0, 1'b1, 0, 1, 1, 0, 1'b0};  // inc ignored in RUN
    vecs[1] = '{1'b1, 1'b1, 1'b0, 0, 1, 2, 1, 1'b0};  // tick applied, enter SET_HR
    vecs[2] = '{1'b1, 1'b0, 1'b0, 0, 1, 2, 1, 1'b0};  // frozen
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1, 1, 2, 1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1, 1, 2, 2, 1'b0};  // mode wins, inc dropped
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1, 2, 2, 2, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1, 2, 2, 2, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1, 2, 0, 0, 1'b0};  // back to RUN clears seconds
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1, 2, 1, 0, 1'b0};

    bus24.tick_1s = 1'b0; bus24.btn_mode = 1'b0; bus24.btn_inc = 1'b0;
    bus12.tick_1s = 1'b0; bus12.btn_mode = 1'b0; bus12.btn_inc = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk24("reset24", 0, 0, 0, 0, 1'b0);
    chk12("reset12", 12, 0, 0, 1'b0, 0, 1'b0);

    for (int k = 0; k < 61; k++) begin
      cyc24(1'b1, 1'b0, 1'b0);
      chk("run61 chime", {31'h0, bus24.chime}, 32'h0);
    end
    chk24("run61", 0, 1, 1, 0, 1'b0);

    for (int k = 0; k < 9; k++) begin
      cyc24(vecs[k].t, vecs[k].m, vecs[k].i);
      chk24($sformatf("vec%0d", k), vecs[k].h, vecs[k].mi, vecs[k].s, vecs[k].md, vecs[k].ch);
    end

    // Asynchronous reset pulse mid-cycle while in SET_MIN with a tick pending.
    cyc24(1'b0, 1'b1, 1'b0);
    cyc24(1'b0, 1'b1, 1'b0);
    chk24("setmin", 1, 2, 1, 2, 1'b0);
    bus24.tick_1s = 1'b1;
    #5 rst_n = 1'b0;
    #1;
    chk24("async24", 0, 0, 0, 0, 1'b0);
    chk12("async12", 12, 0, 0, 1'b0, 0, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    bus24.tick_1s = 1'b0;
    chk24("tick after reset", 0, 0, 1, 0, 1'b0);

    // Hour setting wraps 23 -> 00 with no carry; ticks are ignored meanwhile.
    cyc24(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 25; k++) begin
      cyc24(1'b1, 1'b0, 1'b1);
      if (k == 22) chk24("set hr 23", 23, 0, 1, 1, 1'b0);
      if (k == 23) chk24("set hr wrap", 0, 0, 1, 1, 1'b0);
    end
    chk24("set hr x25", 1, 0, 1, 1, 1'b0);

    // Preload 23:59:58.
    for (int k = 0; k < 22; k++) cyc24(1'b0, 1'b0, 1'b1);
    cyc24(1'b0, 1'b1, 1'b0);
    chk24("to setmin", 23, 0, 1, 2, 1'b0);
    for (int k = 0; k < 59; k++) cyc24(1'b0, 1'b0, 1'b1);
    cyc24(1'b0, 1'b0, 1'b1);
    chk24("set min wrap", 23, 0, 1, 2, 1'b0);
    for (int k = 0; k < 59; k++) cyc24(1'b0, 1'b0, 1'b1);
    cyc24(1'b0, 1'b1, 1'b0);
    chk24("preload", 23, 59, 0, 0, 1'b0);
    for (int k = 0; k < 58; k++) cyc24(1'b1, 1'b0, 1'b0);
    chk24("preload ss", 23, 59, 58, 0, 1'b0);
    cyc24(1'b1, 1'b0, 1'b0);
    chk24("235959", 23, 59, 59, 0, 1'b0);
    cyc24(1'b1, 1'b0, 1'b0);
    chk24("midnight", 0, 0, 0, 0, 1'b1);
    cyc24(1'b0, 1'b0, 1'b0);
    chk24("chime drop", 0, 0, 0, 0, 1'b0);

    // 12-hour instance: set 11:59 am, count through noon and one more hour.
    cyc12(1'b0, 1'b1, 1'b0);
    cyc12(1'b0, 1'b0, 1'b1);
    chk12("h12 12to01", 1, 0, 0, 1'b0, 1, 1'b0);
    for (int k = 0; k < 10; k++) cyc12(1'b0, 1'b0, 1'b1);
    chk12("h12 set 11", 11, 0, 0, 1'b0, 1, 1'b0);
    cyc12(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 59; k++) cyc12(1'b0, 1'b0, 1'b1);
    cyc12(1'b0, 1'b1, 1'b0);
    chk12("h12 preload", 11, 59, 0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 59; k++) cyc12(1'b1, 1'b0, 1'b0);
    chk12("h12 115959", 11, 59, 59, 1'b0, 0, 1'b0);
    cyc12(1'b1, 1'b0, 1'b0);
    chk12("h12 noon", 12, 0, 0, 1'b1, 0, 1'b1);
    for (int k = 0; k < 3600; k++) cyc12(1'b1, 1'b0, 1'b0);
    chk12("h12 one pm", 1, 0, 0, 1'b1, 0, 1'b1);
    cyc12(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cyc12(1'b0, 1'b0, 1'b1);
    chk12("h12 set 11pm", 11, 0, 0, 1'b1, 1, 1'b0);
    cyc12(1'b0, 1'b0, 1'b1);
    chk12("h12 set toggle", 12, 0, 0, 1'b0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
